// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared mode encodings, default 640x480@60 timing and colour helpers
package vga_pkg;

  localparam logic [1:0] MODE_1X = 2'b00;
  localparam logic [1:0] MODE_2X = 2'b01;
  localparam logic [1:0] MODE_4X = 2'b10;

  localparam int DEF_H_ACTIVE     = 640;
  localparam int DEF_H_SYNC_START = 659;
  localparam int DEF_H_SYNC_END   = 754;
  localparam int DEF_H_TOTAL      = 800;
  localparam int DEF_V_ACTIVE     = 480;
  localparam int DEF_V_SYNC_START = 493;
  localparam int DEF_V_SYNC_END   = 494;
  localparam int DEF_V_TOTAL      = 525;

  // Centred window start; an oversized window clips to the active edge.
  function automatic int win_lo(input int active, input int size);
    return (size > active) ? 0 : ((active - size) >> 1);
  endfunction

  function automatic int win_hi(input int active, input int size);
    return (size > active) ? active : (win_lo(active, size) + size);
  endfunction

  // Fill 10 DAC bits by repeating the channel from its MSB downwards.
  function automatic logic [9:0] expand_colour(input logic [15:0] c, input int w);
    logic [9:0] r;
    r = '0;
    for (int i = 0; i < 10; i++) begin
      r[9-i] = c[w-1-(i%w)];
    end
    return r;
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - x/y raster counters, raw sync/active levels and frame_start
module vga_timing_gen #(
  parameter int H_ACTIVE     = 640,
  parameter int H_SYNC_START = 659,
  parameter int H_SYNC_END   = 754,
  parameter int H_TOTAL      = 800,
  parameter int V_ACTIVE     = 480,
  parameter int V_SYNC_START = 493,
  parameter int V_SYNC_END   = 494,
  parameter int V_TOTAL      = 525,
  parameter bit HS_POL       = 1'b0,
  parameter bit VS_POL       = 1'b0,
  parameter int XW           = $clog2(H_TOTAL),
  parameter int YW           = $clog2(V_TOTAL)
) (
  input  logic          vga_clock,
  input  logic          resetn,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          frame_start,
  output logic          frame_end,
  output logic          hsync,
  output logic          vsync,
  output logic          active
);

  logic started;

  assign frame_end = (x == XW'(H_TOTAL - 1)) && (y == YW'(V_TOTAL - 1));
  assign hsync  = (x >= XW'(H_SYNC_START) && x <= XW'(H_SYNC_END)) ? HS_POL : ~HS_POL;
  assign vsync  = (y >= YW'(V_SYNC_START) && y <= YW'(V_SYNC_END)) ? VS_POL : ~VS_POL;
  assign active = (x < XW'(H_ACTIVE)) && (y < YW'(V_ACTIVE));

  // The first cycle after reset release holds (0,0) so frame_start marks it.
  always_ff @(posedge vga_clock or negedge resetn) begin
    if (!resetn) begin
      x           <= '0;
      y           <= '0;
      started     <= 1'b0;
      frame_start <= 1'b0;
    end else if (!started) begin
      started     <= 1'b1;
      frame_start <= 1'b1;
    end else begin
      frame_start <= frame_end;
      if (x == XW'(H_TOTAL - 1)) begin
        x <= '0;
        y <= (y == YW'(V_TOTAL - 1)) ? '0 : y + YW'(1);
      end else begin
        x <= x + XW'(1);
      end
    end
  end

endmodule

// File: rtl/vga_scaler_controller.sv
// rtl/vga_scaler_controller.sv - scaled framebuffer scan-out with border fill and DAC-aligned pipeline
module vga_scaler_controller
  import vga_pkg::*;
#(
  parameter int H_ACTIVE     = DEF_H_ACTIVE,
  parameter int H_SYNC_START = DEF_H_SYNC_START,
  parameter int H_SYNC_END   = DEF_H_SYNC_END,
  parameter int H_TOTAL      = DEF_H_TOTAL,
  parameter int V_ACTIVE     = DEF_V_ACTIVE,
  parameter int V_SYNC_START = DEF_V_SYNC_START,
  parameter int V_SYNC_END   = DEF_V_SYNC_END,
  parameter int V_TOTAL      = DEF_V_TOTAL,
  parameter bit HS_POL       = 1'b0,
  parameter bit VS_POL       = 1'b0,
  parameter int FB_W         = 160,
  parameter int FB_H         = 120,
  parameter int ADDR_W       = 15,
  parameter int COLOR_W      = 8,
  parameter int MEM_LATENCY  = 1
) (
  input  logic                   vga_clock,
  input  logic                   resetn,
  input  logic [1:0]             mode_sel,
  input  logic [3*COLOR_W-1:0]   border_colour,
  input  logic [3*COLOR_W-1:0]   pixel_colour,
  output logic [ADDR_W-1:0]      memory_address,
  output logic                   mem_rd_en,
  output logic                   frame_start,
  output logic [9:0]             VGA_R,
  output logic [9:0]             VGA_G,
  output logic [9:0]             VGA_B,
  output logic                   VGA_HS,
  output logic                   VGA_VS,
  output logic                   VGA_BLANK,
  output logic                   VGA_SYNC,
  output logic                   VGA_CLK
);

  localparam int XW = $clog2(H_TOTAL);
  localparam int YW = $clog2(V_TOTAL);
  localparam int D  = MEM_LATENCY;

  logic [XW-1:0] x, x_lo, x_hi, x_last;
  logic [YW-1:0] y, y_lo, y_hi;
  logic          frame_end, hsync, vsync, active;
  logic [1:0]    mode_s1, mode_s2, eff_mode, sub_max;
  logic [ADDR_W-1:0] row_base, col_addr, cur_col;
  logic [1:0]    sub_x, sub_y, cur_sub;
  logic          in_window, line_start;
  logic [D-1:0]  hs_pipe, vs_pipe, act_pipe, win_pipe;
  logic [3*COLOR_W-1:0] colour_sel;

  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_SYNC_START(H_SYNC_START), .H_SYNC_END(H_SYNC_END), .H_TOTAL(H_TOTAL),
    .V_ACTIVE(V_ACTIVE), .V_SYNC_START(V_SYNC_START), .V_SYNC_END(V_SYNC_END), .V_TOTAL(V_TOTAL),
    .HS_POL(HS_POL), .VS_POL(VS_POL), .XW(XW), .YW(YW)
  ) u_timing (
    .vga_clock  (vga_clock),
    .resetn     (resetn),
    .x          (x),
    .y          (y),
    .frame_start(frame_start),
    .frame_end  (frame_end),
    .hsync      (hsync),
    .vsync      (vsync),
    .active     (active)
  );

  // Window bounds are elaboration-time constants per mode; only the mux is logic.
  always_comb begin
    x_lo    = XW'(win_lo(H_ACTIVE, FB_W << 1));
    x_hi    = XW'(win_hi(H_ACTIVE, FB_W << 1));
    y_lo    = YW'(win_lo(V_ACTIVE, FB_H << 1));
    y_hi    = YW'(win_hi(V_ACTIVE, FB_H << 1));
    sub_max = 2'd1;
    case (eff_mode)
      MODE_1X: begin
        x_lo    = XW'(win_lo(H_ACTIVE, FB_W));
        x_hi    = XW'(win_hi(H_ACTIVE, FB_W));
        y_lo    = YW'(win_lo(V_ACTIVE, FB_H));
        y_hi    = YW'(win_hi(V_ACTIVE, FB_H));
        sub_max = 2'd0;
      end
      MODE_4X: begin
        x_lo    = XW'(win_lo(H_ACTIVE, FB_W << 2));
        x_hi    = XW'(win_hi(H_ACTIVE, FB_W << 2));
        y_lo    = YW'(win_lo(V_ACTIVE, FB_H << 2));
        y_hi    = YW'(win_hi(V_ACTIVE, FB_H << 2));
        sub_max = 2'd3;
      end
      default: ;
    endcase
  end

  assign x_last     = x_hi - XW'(1);
  assign in_window  = (x >= x_lo) && (x < x_hi) && (y >= y_lo) && (y < y_hi);
  assign line_start = (x == x_lo);
  assign cur_col    = line_start ? row_base : col_addr;
  assign cur_sub    = line_start ? 2'd0 : sub_x;

  assign memory_address = in_window ? cur_col : '0;
  assign mem_rd_en      = in_window;
  assign VGA_SYNC       = 1'b1;
  assign VGA_CLK        = vga_clock;

  always_ff @(posedge vga_clock or negedge resetn) begin
    if (!resetn) begin
      mode_s1  <= MODE_2X;
      mode_s2  <= MODE_2X;
      eff_mode <= MODE_2X;
      row_base <= '0;
      col_addr <= '0;
      sub_x    <= '0;
      sub_y    <= '0;
    end else begin
      mode_s1 <= mode_sel;
      mode_s2 <= mode_s1;
      if (frame_end) begin
        eff_mode <= (mode_s2 == MODE_1X || mode_s2 == MODE_4X) ? mode_s2 : MODE_2X;
        row_base <= '0;
        sub_y    <= '0;
      end else if (in_window) begin
        if (cur_sub == sub_max) begin
          sub_x    <= 2'd0;
          col_addr <= cur_col + ADDR_W'(1);
        end else begin
          sub_x    <= cur_sub + 2'd1;
          col_addr <= cur_col;
        end
        if (x == x_last) begin
          if (sub_y == sub_max) begin
            sub_y    <= 2'd0;
            row_base <= row_base + ADDR_W'(FB_W);
          end else begin
            sub_y <= sub_y + 2'd1;
          end
        end
      end
    end
  end

  // Stage D-1 lines up with pixel_colour for the same pixel.
  always_comb begin
    colour_sel = '0;
    if (win_pipe[D-1])
      colour_sel = pixel_colour;
    else if (act_pipe[D-1])
      colour_sel = border_colour;
  end

  always_ff @(posedge vga_clock or negedge resetn) begin
    if (!resetn) begin
      hs_pipe   <= {D{~HS_POL}};
      vs_pipe   <= {D{~VS_POL}};
      act_pipe  <= '0;
      win_pipe  <= '0;
      VGA_HS    <= ~HS_POL;
      VGA_VS    <= ~VS_POL;
      VGA_BLANK <= 1'b0;
      VGA_R     <= '0;
      VGA_G     <= '0;
      VGA_B     <= '0;
    end else begin
      hs_pipe[0]  <= hsync;
      vs_pipe[0]  <= vsync;
      act_pipe[0] <= active;
      win_pipe[0] <= in_window;
      for (int i = 1; i < D; i++) begin
        hs_pipe[i]  <= hs_pipe[i-1];
        vs_pipe[i]  <= vs_pipe[i-1];
        act_pipe[i] <= act_pipe[i-1];
        win_pipe[i] <= win_pipe[i-1];
      end
      VGA_HS    <= hs_pipe[D-1];
      VGA_VS    <= vs_pipe[D-1];
      VGA_BLANK <= act_pipe[D-1];
      VGA_R     <= expand_colour(16'(colour_sel[3*COLOR_W-1 -: COLOR_W]), COLOR_W);
      VGA_G     <= expand_colour(16'(colour_sel[2*COLOR_W-1 -: COLOR_W]), COLOR_W);
      VGA_B     <= expand_colour(16'(colour_sel[COLOR_W-1 -: COLOR_W]), COLOR_W);
    end
  end

endmodule
